pmp_csr_initiator: RTL and testbench
====================================

Name: pmp_csr_initiator

Overview:
- Requester side of the PMP CSR access interface; drives the PMP block's CSR request port.
- Accepts one decoded Zicsr instruction at a time from the execute stage over a valid/ready handshake.
- Derives read/write intent per RISC-V rules and issues a single request. Captures read data and exception status, then pulses the response-acknowledge that clears the PMP's sticky state.
- Returns the result to writeback over a second valid/ready handshake. Sits between the execute stage and the pmp block.

Parameters:
- REG_WIDTH, 32, width of rs1 value and CSR data.
- TIMEOUT_CYCLES, 16, cycles to hold a request without csr_req_rvalid before aborting; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid from execute
- in_ready  out  1  initiator can accept
- in_funct3  in  3  Zicsr funct3
- in_csr_addr  in  12  CSR address
- in_rs1_val  in  REG_WIDTH  rs1 operand
- in_uimm  in  5  rs1 field / zimm
- in_rd_idx  in  5  destination register
- flush  in  1  pipeline kill
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_rd_idx  out  5  destination register
- out_rd_wen  out  1  rd write enable
- out_rdata  out  REG_WIDTH  old CSR value
- out_exc  out  2  00 none, 01 access fault, 10 illegal funct3, 11 timeout
- csr_req_en  out  1  request strobe
- csr_req_op  out  2  [1]=read, [0]=write
- csr_funct3  out  3  registered funct3
- csr_imm  out  5  registered zimm
- rs1_val  out  REG_WIDTH  registered rs1
- csr_req_addr  out  12  registered address
- csr_rrsp  out  1  response acknowledge pulse
- csr_req_rdata  in  32  read data, valid while csr_req_en
- csr_req_rvalid  in  1  response valid
- csr_act_rsp  in  3  [1]=exception

Behaviour:
- Reset: state IDLE. in_ready=1. All other outputs 0, including csr_req_en, csr_req_op, csr_rrsp, out_valid, out_exc, out_rdata and the registered request fields.
- Op derivation, latched at accept. Read is suppressed only for CSRRW (001) and CSRRWI (101) when rd==0. Write is suppressed for CSRRS/CSRRC/CSRRSI/CSRRCI (010/011/110/111) when uimm==0; all others write. funct3 000 or 100 is illegal.
- FSM states: IDLE, REQ, RRSP, DONE.
  - IDLE: in_ready=1. On in_valid&&!flush, latch all fields.
    - Legal funct3 -> REQ.
    - Illegal funct3 -> DONE with out_exc=10, out_rd_wen=0, no request issued.
  - REQ: csr_req_en=1 with latched op, address and operands held stable; timeout counter increments each cycle.
    - If csr_act_rsp[1]: capture out_exc=01, out_rd_wen=0 -> RRSP. Exception has priority over rvalid in the same cycle.
    - Else if csr_req_rvalid: capture csr_req_rdata into out_rdata (same cycle; PMP rdata is combinational); out_rd_wen = op[1] && rd!=0 -> RRSP.
    - Else if counter reaches TIMEOUT_CYCLES-1: out_exc=11, out_rd_wen=0 -> RRSP.
  - RRSP: csr_req_en=0, csr_rrsp=1 for exactly one cycle, clearing the PMP sticky read_valid/exception -> DONE, or IDLE if the drop flag is set.
  - DONE: out_valid=1, outputs stable until out_ready; on out_ready -> IDLE with out_valid=0 next cycle. No back-to-back acceptance in the DONE cycle.
- Latency: a legal request with immediate rvalid has accept T, csr_req_en T+1, csr_rrsp T+2, out_valid T+3.
- Flush:
  - In IDLE or DONE -> IDLE next cycle, out_valid dropped.
  - In REQ -> deassert csr_req_en and go RRSP with the drop flag set; the rrsp pulse must still occur, then IDLE.
  - In RRSP -> set the drop flag only.
- Flush on the same cycle as in_valid in IDLE: the instruction is not accepted.
- Counter clears on entry to REQ; it does not wrap.
- Reset mid-transaction: immediate return to reset values; no rrsp is emitted.

Test Plan:
- CSRRS addr 0x3B0, rs1=0x0000_1000, rd=5; PMP returns rvalid+rdata 0x2000_0000 on the en cycle -> op=11, en one cycle, rrsp next, out_rdata=0x2000_0000, rd_wen=1, out_exc=00, total 3 cycles.
- CSRRW rd=0 addr 0x3A0 -> csr_req_op=01, out_rd_wen=0. CSRRSI uimm=0 rd=3 -> csr_req_op=10.
- mode_state non-machine, CSRRW to 0x3A0 -> csr_act_rsp[1]=1 during en -> out_exc=01, rd_wen=0, rrsp pulsed once.
- funct3=100 -> no csr_req_en ever, out_valid one cycle after accept with out_exc=10.
- Responder never raises rvalid, TIMEOUT_CYCLES=4 -> en high exactly 4 cycles, then rrsp, out_exc=11. Also: flush on 2nd REQ cycle -> en drops, rrsp pulses, out_valid never asserts.
- out_ready held low 5 cycles in DONE -> out_valid and outputs stable, in_ready=0; release -> IDLE, next instruction accepted the following cycle.

Source files
------------

// File: rtl/pmp_csr_initiator_if.sv
// rtl/pmp_csr_initiator_if.sv - execute, writeback and PMP CSR request signals of the initiator
interface pmp_csr_initiator_if #(
    parameter int REG_WIDTH = 32
);
    // Execute-stage instruction handshake
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_funct3;
    logic [11:0]          in_csr_addr;
    logic [REG_WIDTH-1:0] in_rs1_val;
    logic [4:0]           in_uimm;
    logic [4:0]           in_rd_idx;

    // Writeback result handshake
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_rd_idx;
    logic                 out_rd_wen;
    logic [REG_WIDTH-1:0] out_rdata;
    logic [1:0]           out_exc;

    // PMP CSR request port
    logic                 csr_req_en;
    logic [1:0]           csr_req_op;
    logic [2:0]           csr_funct3;
    logic [4:0]           csr_imm;
    logic [REG_WIDTH-1:0] rs1_val;
    logic [11:0]          csr_req_addr;
    logic                 csr_rrsp;
    logic [31:0]          csr_req_rdata;
    logic                 csr_req_rvalid;
    logic [2:0]           csr_act_rsp;

    modport master (
        input  in_valid, in_funct3, in_csr_addr, in_rs1_val, in_uimm, in_rd_idx,
        output in_ready,
        output out_valid, out_rd_idx, out_rd_wen, out_rdata, out_exc,
        input  out_ready,
        output csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val, csr_req_addr, csr_rrsp,
        input  csr_req_rdata, csr_req_rvalid, csr_act_rsp
    );

    modport slave (
        output in_valid, in_funct3, in_csr_addr, in_rs1_val, in_uimm, in_rd_idx,
        input  in_ready,
        input  out_valid, out_rd_idx, out_rd_wen, out_rdata, out_exc,
        output out_ready,
        input  csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val, csr_req_addr, csr_rrsp,
        output csr_req_rdata, csr_req_rvalid, csr_act_rsp
    );
endinterface

// File: rtl/pmp_csr_initiator.sv
// rtl/pmp_csr_initiator.sv - issues one Zicsr access to the PMP block and returns the result to writeback
module pmp_csr_initiator #(
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    pmp_csr_initiator_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, RRSP, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic       drop_q;

    logic       accept;
    logic       illegal;
    logic       rd_intent;
    logic       wr_intent;
    logic       timeout_hit;

    // Only the exception bit of the PMP action response matters here
    logic       unused_rsp_bits;
    assign unused_rsp_bits = bus.csr_act_rsp[2] ^ bus.csr_act_rsp[0];

    // CSRRW/CSRRWI with rd==0 skip the read; set/clear forms with a zero source skip the write
    always_comb begin
        accept      = (state_q == IDLE) && bus.in_valid && !flush;
        illegal     = (bus.in_funct3[1:0] == 2'b00);
        rd_intent   = !((bus.in_funct3[1:0] == 2'b01) && (bus.in_rd_idx == 5'd0));
        wr_intent   = !(bus.in_funct3[1] && (bus.in_uimm == 5'd0));
        timeout_hit = (cnt_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_d        = state_q;
        bus.in_ready   = 1'b0;
        bus.csr_req_en = 1'b0;
        bus.csr_rrsp   = 1'b0;
        bus.out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_d = illegal ? DONE : REQ;
            end
            REQ: begin
                bus.csr_req_en = !flush;
                if (flush || bus.csr_act_rsp[1] || bus.csr_req_rvalid || timeout_hit)
                    state_d = RRSP;
            end
            RRSP: begin
                bus.csr_rrsp = 1'b1;
                state_d      = (drop_q || flush) ? IDLE : DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (flush || bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields latched at accept, response captured while the request is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.csr_req_op   <= 2'b00;
            bus.csr_funct3   <= 3'b000;
            bus.csr_imm      <= 5'd0;
            bus.rs1_val      <= '0;
            bus.csr_req_addr <= 12'h000;
            bus.out_rd_idx   <= 5'd0;
            bus.out_rd_wen   <= 1'b0;
            bus.out_rdata    <= '0;
            bus.out_exc      <= 2'b00;
            cnt_q            <= 8'd0;
            drop_q           <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus.csr_req_op   <= illegal ? 2'b00 : {rd_intent, wr_intent};
                        bus.csr_funct3   <= bus.in_funct3;
                        bus.csr_imm      <= bus.in_uimm;
                        bus.rs1_val      <= bus.in_rs1_val;
                        bus.csr_req_addr <= bus.in_csr_addr;
                        bus.out_rd_idx   <= bus.in_rd_idx;
                        bus.out_rd_wen   <= 1'b0;
                        bus.out_rdata    <= '0;
                        bus.out_exc      <= illegal ? 2'b10 : 2'b00;
                        cnt_q            <= 8'd0;
                        drop_q           <= 1'b0;
                    end
                end
                REQ: begin
                    // Bounded: REQ is left no later than the cycle cnt_q hits CNT_LAST
                    cnt_q <= cnt_q + 8'd1;
                    if (flush) begin
                        drop_q <= 1'b1;
                    end else if (bus.csr_act_rsp[1]) begin
                        bus.out_exc    <= 2'b01;
                        bus.out_rd_wen <= 1'b0;
                    end else if (bus.csr_req_rvalid) begin
                        bus.out_rdata  <= REG_WIDTH'(bus.csr_req_rdata);
                        bus.out_rd_wen <= bus.csr_req_op[1] && (bus.out_rd_idx != 5'd0);
                    end else if (timeout_hit) begin
                        bus.out_exc    <= 2'b11;
                        bus.out_rd_wen <= 1'b0;
                    end
                end
                RRSP: begin
                    if (flush) drop_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pmp_csr_initiator.sv
// tb/tb_pmp_csr_initiator.sv - directed self-checking bench for pmp_csr_initiator
module tb_pmp_csr_initiator;
    logic clk;
    logic rst_n;
    logic flush;
    int   vectors;
    int   miscompares;

    pmp_csr_initiator_if #(.REG_WIDTH(32)) bus ();

    pmp_csr_initiator #(.REG_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] uimm, input logic [4:0] rd);
        bus.in_funct3   = f3;
        bus.in_csr_addr = addr;
        bus.in_rs1_val  = rs1;
        bus.in_uimm     = uimm;
        bus.in_rd_idx   = rd;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid    = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.csr_req_rvalid = 1'b1;
        bus.csr_req_rdata  = data;
        tick();
        bus.csr_req_rvalid = 1'b0;
        bus.csr_req_rdata  = 32'h0;
    endtask

    task automatic retire;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL reset_req_en got %b want 0", bus.csr_req_en); end
        vectors++; if (bus.csr_req_op !== 2'b00) begin miscompares++; $display("FAIL reset_req_op got %b want 00", bus.csr_req_op); end
        vectors++; if (bus.csr_rrsp !== 1'b0) begin miscompares++; $display("FAIL reset_rrsp got %b want 0", bus.csr_rrsp); end
        vectors++; if (bus.out_exc !== 2'b00) begin miscompares++; $display("FAIL reset_out_exc got %b want 00", bus.out_exc); end
        vectors++; if (bus.out_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_out_rdata got %h want 0", bus.out_rdata); end
        vectors++; if (bus.csr_req_addr !== 12'h0) begin miscompares++; $display("FAIL reset_req_addr got %h want 0", bus.csr_req_addr); end
        vectors++; if (bus.rs1_val !== 32'h0) begin miscompares++; $display("FAIL reset_rs1_val got %h want 0", bus.rs1_val); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_csrrs_read;
        issue(3'b010, 12'h3B0, 32'h0000_1000, 5'd7, 5'd5);
        vectors++; if (bus.csr_req_en !== 1'b1) begin miscompares++; $display("FAIL rs_req_en got %b want 1", bus.csr_req_en); end
        vectors++; if (bus.csr_req_op !== 2'b11) begin miscompares++; $display("FAIL rs_req_op got %b want 11", bus.csr_req_op); end
        vectors++; if (bus.csr_req_addr !== 12'h3B0) begin miscompares++; $display("FAIL rs_req_addr got %h want 3b0", bus.csr_req_addr); end
        vectors++; if (bus.rs1_val !== 32'h0000_1000) begin miscompares++; $display("FAIL rs_rs1_val got %h want 00001000", bus.rs1_val); end
        vectors++; if (bus.csr_funct3 !== 3'b010) begin miscompares++; $display("FAIL rs_funct3 got %b want 010", bus.csr_funct3); end
        respond(32'h2000_0000);
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL rs_en_drop got %b want 0", bus.csr_req_en); end
        vectors++; if (bus.csr_rrsp !== 1'b1) begin miscompares++; $display("FAIL rs_rrsp got %b want 1", bus.csr_rrsp); end
        tick();
        vectors++; if (bus.csr_rrsp !== 1'b0) begin miscompares++; $display("FAIL rs_rrsp_once got %b want 0", bus.csr_rrsp); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL rs_out_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_rdata !== 32'h2000_0000) begin miscompares++; $display("FAIL rs_out_rdata got %h want 20000000", bus.out_rdata); end
        vectors++; if (bus.out_rd_wen !== 1'b1) begin miscompares++; $display("FAIL rs_rd_wen got %b want 1", bus.out_rd_wen); end
        vectors++; if (bus.out_exc !== 2'b00) begin miscompares++; $display("FAIL rs_out_exc got %b want 00", bus.out_exc); end
        vectors++; if (bus.out_rd_idx !== 5'd5) begin miscompares++; $display("FAIL rs_rd_idx got %0d want 5", bus.out_rd_idx); end
        retire();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_retire_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rs_retire_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_op_derivation;
        issue(3'b001, 12'h3A0, 32'hDEAD_BEEF, 5'd2, 5'd0);
        vectors++; if (bus.csr_req_op !== 2'b01) begin miscompares++; $display("FAIL rw_rd0_op got %b want 01", bus.csr_req_op); end
        vectors++; if (bus.rs1_val !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rw_rs1_val got %h want deadbeef", bus.rs1_val); end
        respond(32'h0000_0055);
        tick();
        vectors++; if (bus.out_rd_wen !== 1'b0) begin miscompares++; $display("FAIL rw_rd0_wen got %b want 0", bus.out_rd_wen); end
        retire();
        issue(3'b110, 12'h3B4, 32'h0, 5'd0, 5'd3);
        vectors++; if (bus.csr_req_op !== 2'b10) begin miscompares++; $display("FAIL rsi_z_op got %b want 10", bus.csr_req_op); end
        vectors++; if (bus.csr_imm !== 5'd0) begin miscompares++; $display("FAIL rsi_z_imm got %0d want 0", bus.csr_imm); end
        respond(32'h1234_5678);
        tick();
        vectors++; if (bus.out_rd_wen !== 1'b1) begin miscompares++; $display("FAIL rsi_z_wen got %b want 1", bus.out_rd_wen); end
        vectors++; if (bus.out_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL rsi_z_rdata got %h want 12345678", bus.out_rdata); end
        retire();
        issue(3'b101, 12'h3A1, 32'h0, 5'd9, 5'd7);
        vectors++; if (bus.csr_req_op !== 2'b11) begin miscompares++; $display("FAIL rwi_op got %b want 11", bus.csr_req_op); end
        vectors++; if (bus.csr_imm !== 5'd9) begin miscompares++; $display("FAIL rwi_imm got %0d want 9", bus.csr_imm); end
        respond(32'h0);
        tick();
        retire();
    endtask

    task automatic test_access_fault;
        issue(3'b001, 12'h3A0, 32'h0000_00FF, 5'd1, 5'd4);
        vectors++; if (bus.csr_req_en !== 1'b1) begin miscompares++; $display("FAIL af_req_en got %b want 1", bus.csr_req_en); end
        bus.csr_act_rsp = 3'b010;
        respond(32'h0000_FFFF);
        bus.csr_act_rsp = 3'b000;
        vectors++; if (bus.csr_rrsp !== 1'b1) begin miscompares++; $display("FAIL af_rrsp got %b want 1", bus.csr_rrsp); end
        tick();
        vectors++; if (bus.csr_rrsp !== 1'b0) begin miscompares++; $display("FAIL af_rrsp_once got %b want 0", bus.csr_rrsp); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL af_out_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_exc !== 2'b01) begin miscompares++; $display("FAIL af_out_exc got %b want 01", bus.out_exc); end
        vectors++; if (bus.out_rd_wen !== 1'b0) begin miscompares++; $display("FAIL af_rd_wen got %b want 0", bus.out_rd_wen); end
        retire();
    endtask

    task automatic test_illegal;
        issue(3'b100, 12'h3A0, 32'h1, 5'd1, 5'd6);
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL ill_req_en got %b want 0", bus.csr_req_en); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL ill_out_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_exc !== 2'b10) begin miscompares++; $display("FAIL ill_out_exc got %b want 10", bus.out_exc); end
        vectors++; if (bus.out_rd_wen !== 1'b0) begin miscompares++; $display("FAIL ill_rd_wen got %b want 0", bus.out_rd_wen); end
        retire();
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL ill_after_en got %b want 0", bus.csr_req_en); end
        issue(3'b000, 12'h3A0, 32'h1, 5'd1, 5'd6);
        vectors++; if (bus.out_exc !== 2'b10) begin miscompares++; $display("FAIL ill000_exc got %b want 10", bus.out_exc); end
        retire();
    endtask

    task automatic test_timeout;
        int en_cycles;
        en_cycles = 0;
        issue(3'b011, 12'h3B1, 32'h0000_0F00, 5'd1, 5'd2);
        for (int i = 0; i < 20 && bus.csr_req_en === 1'b1; i++) begin
            en_cycles++;
            tick();
        end
        vectors++; if (en_cycles != 4) begin miscompares++; $display("FAIL to_en_cycles got %0d want 4", en_cycles); end
        vectors++; if (bus.csr_rrsp !== 1'b1) begin miscompares++; $display("FAIL to_rrsp got %b want 1", bus.csr_rrsp); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL to_out_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_exc !== 2'b11) begin miscompares++; $display("FAIL to_out_exc got %b want 11", bus.out_exc); end
        vectors++; if (bus.out_rd_wen !== 1'b0) begin miscompares++; $display("FAIL to_rd_wen got %b want 0", bus.out_rd_wen); end
        retire();
    endtask

    task automatic test_flush;
        bus.in_funct3 = 3'b010; bus.in_csr_addr = 12'h3B0; bus.in_uimm = 5'd1; bus.in_rd_idx = 5'd1;
        bus.in_valid = 1'b1;
        flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        flush = 1'b0;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fl_idle_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL fl_idle_en got %b want 0", bus.csr_req_en); end
        issue(3'b001, 12'h3A2, 32'h7, 5'd1, 5'd1);
        vectors++; if (bus.csr_req_en !== 1'b1) begin miscompares++; $display("FAIL fl_req1_en got %b want 1", bus.csr_req_en); end
        tick();
        flush = 1'b1;
        #1;
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL fl_req2_en got %b want 0", bus.csr_req_en); end
        tick();
        flush = 1'b0;
        vectors++; if (bus.csr_rrsp !== 1'b1) begin miscompares++; $display("FAIL fl_rrsp got %b want 1", bus.csr_rrsp); end
        tick();
        vectors++; if (bus.csr_rrsp !== 1'b0) begin miscompares++; $display("FAIL fl_rrsp_once got %b want 0", bus.csr_rrsp); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fl_back_idle got %b want 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_no_valid cycle %0d got %b want 0", i, bus.out_valid); end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        issue(3'b010, 12'h3B2, 32'h0, 5'd3, 5'd9);
        respond(32'hA5A5_0001);
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid cycle %0d got %b want 1", i, bus.out_valid); end
            vectors++; if (bus.out_rdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL bp_rdata cycle %0d got %h want a5a50001", i, bus.out_rdata); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, bus.in_ready); end
            vectors++; if (bus.out_rd_idx !== 5'd9) begin miscompares++; $display("FAIL bp_rd_idx cycle %0d got %0d want 9", i, bus.out_rd_idx); end
            tick();
        end
        bus.out_ready = 1'b1;
        bus.in_funct3 = 3'b001; bus.in_csr_addr = 12'h3A0; bus.in_rs1_val = 32'h55; bus.in_uimm = 5'd1; bus.in_rd_idx = 5'd0;
        bus.in_valid = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_done_ready got %b want 0", bus.in_ready); end
        tick();
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop got %b want 0", bus.out_valid); end
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_en got %b want 0", bus.csr_req_en); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (bus.csr_req_en !== 1'b1) begin miscompares++; $display("FAIL b2b_next_en got %b want 1", bus.csr_req_en); end
        vectors++; if (bus.csr_req_addr !== 12'h3A0) begin miscompares++; $display("FAIL b2b_next_addr got %h want 3a0", bus.csr_req_addr); end
        vectors++; if (bus.csr_req_op !== 2'b01) begin miscompares++; $display("FAIL b2b_next_op got %b want 01", bus.csr_req_op); end
        respond(32'h0);
        tick();
        retire();
    endtask

    task automatic test_reset_mid;
        issue(3'b011, 12'h3B3, 32'h9, 5'd4, 5'd8);
        vectors++; if (bus.csr_req_en !== 1'b1) begin miscompares++; $display("FAIL rm_req_en got %b want 1", bus.csr_req_en); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.csr_req_en !== 1'b0) begin miscompares++; $display("FAIL rm_en_async got %b want 0", bus.csr_req_en); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready_async got %b want 1", bus.in_ready); end
        vectors++; if (bus.csr_req_addr !== 12'h0) begin miscompares++; $display("FAIL rm_addr_async got %h want 0", bus.csr_req_addr); end
        tick();
        vectors++; if (bus.csr_rrsp !== 1'b0) begin miscompares++; $display("FAIL rm_no_rrsp got %b want 0", bus.csr_rrsp); end
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.csr_rrsp !== 1'b0) begin miscompares++; $display("FAIL rm_no_rrsp_after got %b want 0", bus.csr_rrsp); end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_n              = 1'b0;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_funct3      = 3'b000;
        bus.in_csr_addr    = 12'h000;
        bus.in_rs1_val     = 32'h0;
        bus.in_uimm        = 5'd0;
        bus.in_rd_idx      = 5'd0;
        bus.out_ready      = 1'b0;
        bus.csr_req_rdata  = 32'h0;
        bus.csr_req_rvalid = 1'b0;
        bus.csr_act_rsp    = 3'b000;

        test_reset();
        test_csrrs_read();
        test_op_derivation();
        test_access_fault();
        test_illegal();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
